// File: rtl/noc_fifo_pm_rd.sv
// noc_fifo_pm_rd: PM-side read port of the NoC->PM asynchronous packet FIFO.
// Latency: a write-pointer change shows up as out_valid_o SYNC_STAGES+1 edges later; 1 packet/cycle sustained.
// Backpressure: out_valid_o && !out_ready_i freezes the output word and both pointers; only level_o tracks the writer.
//
// Ports:
//   clk_i, reset_n_i  PM clock, asynchronous active-low reset
//   fifo_data_i       writer-side memory word addressed by fifo_raddr_o (read combinationally)
//   fifo_waddr_i      gray-coded write pointer from the writer clock domain
//   fifo_raddr_o      registered gray-coded read pointer returned to the writer domain
//   out_valid_o/out_data_o/out_ready_i  registered valid/ready packet output
//   level_o           registered count of entries visible in the FIFO, excluding the output register

`ifndef NOC_ASYNC_FIFO_PACKET_SIZE
`define NOC_ASYNC_FIFO_PACKET_SIZE 32
`endif
`ifndef NOC_ASYNC_FIFO_AWIDTH
`define NOC_ASYNC_FIFO_AWIDTH 3
`endif

module noc_fifo_pm_rd #(
  parameter int PACKET_SIZE = `NOC_ASYNC_FIFO_PACKET_SIZE,
  parameter int AWIDTH      = `NOC_ASYNC_FIFO_AWIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [PACKET_SIZE-1:0] fifo_data_i,
  input  logic [AWIDTH:0]        fifo_waddr_i,
  output logic [AWIDTH:0]        fifo_raddr_o,
  output logic                   out_valid_o,
  output logic [PACKET_SIZE-1:0] out_data_o,
  input  logic                   out_ready_i,
  output logic [AWIDTH:0]        level_o
);

  localparam int PW = AWIDTH + 1;

  // Write-pointer synchroniser. The raw input feeds only the first stage.
  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] w_wptr_gray_s;
  logic [PW-1:0] w_wptr_bin_s;

  logic [PW-1:0] r_rptr_bin;
  logic [PW-1:0] w_rptr_bin_next;
  logic [PW-1:0] w_raddr_next;
  logic          w_empty;
  logic          w_fetch;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= fifo_waddr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_wptr_gray_s = r_sync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_wptr_bin_s = '0;
    for (int i = 0; i < PW; i++) begin
      w_wptr_bin_s[i] = ^(w_wptr_gray_s >> i);
    end
  end

  // Comparing in the gray domain against the registered read pointer avoids a
  // second conversion; the reader can never see the FIFO as full.
  assign w_empty = (w_wptr_gray_s == fifo_raddr_o);

  // Load the output register whenever it is free or being consumed this cycle.
  assign w_fetch = !w_empty && (!out_valid_o || out_ready_i);

  assign w_rptr_bin_next = w_fetch ? (r_rptr_bin + PW'(1)) : r_rptr_bin;
  assign w_raddr_next    = w_rptr_bin_next ^ (w_rptr_bin_next >> 1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr_bin   <= '0;
      fifo_raddr_o <= '0;
      level_o      <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
    end else begin
      r_rptr_bin   <= w_rptr_bin_next;
      fifo_raddr_o <= w_raddr_next;
      // Modulo-2^PW subtraction handles pointer wrap with no special case.
      level_o      <= w_wptr_bin_s - w_rptr_bin_next;
      if (w_fetch) begin
        out_data_o  <= fifo_data_i;
        out_valid_o <= 1'b1;
      end else if (out_valid_o && out_ready_i) begin
        // Drain: the word is consumed and nothing replaces it; data is left as-is.
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/noc_fifo_pm_rd.md
# noc_fifo_pm_rd

PM-side read port of the NoC→PM asynchronous packet FIFO. It sits between the FIFO inputs of the PM module (`noc_fifo_pm_in_data_i`, `noc_fifo_pm_in_waddr_i`, `noc_fifo_pm_in_raddr_o`) and the core-side packet consumer. It synchronises the writer's gray-coded write pointer into the PM clock domain, detects non-empty, and pulls one packet per cycle into a registered valid/ready output stage. It returns the gray-coded read pointer to the writer domain. The FIFO memory lives on the writer side and is read combinationally at the address given by `raddr_o`.

## Interface
Parameters:
- `PACKET_SIZE`, default `NOC_ASYNC_FIFO_PACKET_SIZE`: packet width in bits.
- `AWIDTH`, default `NOC_ASYNC_FIFO_AWIDTH`: FIFO depth is 2^AWIDTH; pointers are AWIDTH+1 bits.
- `SYNC_STAGES`, default 2: flop stages on the write-pointer synchroniser (minimum 2).

Ports:
- `clk_i`  in  1  PM clock.
- `reset_n_i`  in  1  Reset, asynchronous, active-low.
- `fifo_data_i`  in  PACKET_SIZE  Writer-side memory word at `raddr_o`.
- `fifo_waddr_i`  in  AWIDTH+1  Gray-coded write pointer from the writer domain (asynchronous).
- `fifo_raddr_o`  out  AWIDTH+1  Gray-coded read pointer to the writer domain; registered.
- `out_valid_o`  out  1  Output packet valid.
- `out_data_o`  out  PACKET_SIZE  Output packet; registered.
- `out_ready_i`  in  1  Consumer accepts the packet.
- `level_o`  out  AWIDTH+1  Entries visible in the FIFO (synchronised write pointer minus read pointer). Excludes the output register.

## Operation
- **Synchroniser.** `fifo_waddr_i` passes through SYNC_STAGES flops to give `wptr_gray_s`. The value is converted gray→binary to give `wptr_bin_s`. No other logic touches the raw input.
- **Read pointer.** `rptr_bin` is AWIDTH+1 bits. `fifo_raddr_o` is registered `rptr_bin ^ (rptr_bin>>1)`. It changes in exactly one bit per increment.
- **Empty.** `empty = (wptr_gray_s == fifo_raddr_o)`. The FIFO is never full from the reader's view. Level ranges from 0 to 2^AWIDTH.
- **Fetch.** `fetch = !empty && (!out_valid_o || out_ready_i)`. On fetch:
  - `out_data_o <= fifo_data_i`
  - `out_valid_o <= 1`
  - `rptr_bin <= rptr_bin + 1`, with the gray register updated on the same edge.
- **Drain.** When `out_valid_o && out_ready_i && empty`, then `out_valid_o <= 0` and `out_data_o` holds its value.
- **Stall.** When `out_valid_o && !out_ready_i`: `out_data_o`, `out_valid_o` and the pointers are frozen, and `fifo_data_i` is ignored.
- **Simultaneous events.** Accept and fetch in the same cycle replace the output word, giving 1 packet/cycle sustained. A writer pointer update arriving while stalled is only reflected in `level_o`.
- **Wrap-around.** Pointers wrap modulo 2^(AWIDTH+1) with no special case. The memory index is `rptr_bin[AWIDTH-1:0]`, which the writer side decodes from the gray pointer.
- **Level.** `level_o <= wptr_bin_s - rptr_bin_next`, unsigned and modulo 2^(AWIDTH+1). It is registered.

## Timing
- **Reset values** (asynchronous assert; outputs valid immediately):
  - `fifo_raddr_o = 0`
  - `out_valid_o = 0`
  - `out_data_o = 0`
  - `level_o = 0`
  - synchroniser flops = 0
  - `rptr_bin = 0`
- **Release.** Reset release is assumed synchronous to `clk_i`, handled by the upstream reset synchroniser.
- **Latency.** A change on `fifo_waddr_i` before edge N is seen as non-empty after edge N+SYNC_STAGES-1. The fetch happens on edge N+SYNC_STAGES, so `out_valid_o` rises SYNC_STAGES+1 edges after the input is sampled. With SYNC_STAGES=2, that is 3 cycles.
- **Data stability.** `fifo_data_i` is sampled one cycle after `fifo_raddr_o` changes, at the earliest. The address path is treated as a same-domain combinational path. The data word is stable by construction, because the writer updated the memory before publishing `waddr`.
- **Reset mid-operation.** The output packet is dropped and the pointers return to 0. The writer side must be reset together with this block; there is no partial resynchronisation.
- **Throughput.** One packet per cycle while not empty and `out_ready_i=1`.

## Test plan
All scenarios use AWIDTH=3 (depth 8) and SYNC_STAGES=2.

1. **Reset.** Assert `reset_n_i=0` mid-clock -> all outputs 0 immediately; `fifo_raddr_o=0` held through 5 cycles after release with `fifo_waddr_i=0`.
2. **Single packet.** Writer publishes one packet 0xA5 and `waddr` goes 0→1 (gray) -> `out_valid_o=1` with data 0xA5 exactly 3 cycles later. With `ready=1`, valid drops the next cycle; `fifo_raddr_o=1`, `level_o=0`.
3. **Full burst.** 8 packets preloaded, `waddr` gray of 8 (0b1100), ready held high -> 8 consecutive valid cycles with data in order. `fifo_raddr_o` takes the gray sequence 0,1,3,2,6,7,5,4,12 (one bit change per step). `level_o` counts 8→0.
4. **Backpressure.** 4 packets, ready low for 10 cycles -> first packet held stable and `fifo_raddr_o=1` frozen. Then ready toggles 1/0 -> packets 2-4 are delivered only in ready=1 cycles, with no loss or duplication.
5. **Wrap-around.** 40 packets streamed with a random ready pattern and a writer that respects depth 8 -> all 40 are received in order. The pointer passes 15→0 twice; `level_o` never exceeds 8.
6. **Reset mid-burst.** Reset asserted while `out_valid_o=1` and `level_o=5` -> all outputs return to 0 asynchronously. After release and a writer reset, a new packet 0x3C is delivered 3 cycles after `waddr=1`.
